// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and sizing helpers for the iterative multiply/divide unit
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH) + 1;

    // Iteration counter width for a given operand width; one spare bit so WIDTH itself fits.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - operand/control/result bundle between the execute stage and multdiv_iter
interface multdiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             data_busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, data_busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, data_busy
    );
endinterface

// File: rtl/multdiv_iter_counter.sv
// rtl/multdiv_iter_counter.sv - iteration up-counter with synchronous clear and terminal-count flag
module iter_counter #(
    parameter int CW = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] last_i,
    output logic          tc_o
);
    logic [CW-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // High during the final iteration so the FSM can leave on that same edge.
    assign tc_o = (count_q == last_i);
endmodule

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed Booth multiply / non-restoring divide unit
// MULTDIV_BOOTH4_EN selects the radix-4 Booth multiply path (default radix-2).
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clock,
    input logic      reset_n,
    multdiv_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
`ifdef MULTDIV_BOOTH4_EN
    localparam int MULT_ITERS = WIDTH / 2;
`else
    localparam int MULT_ITERS = WIDTH;
`endif
    localparam logic [CW-1:0]    MULT_LAST = CW'(MULT_ITERS - 1);
    localparam logic [CW-1:0]    DIV_LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    state_e           state_q;
    op_e              op_q;
    logic [2*WIDTH:0] prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH:0]   rem_q, rem_d, rem_shift;
    logic [WIDTH-1:0] quo_q, quo_d, dvsr_q;
    logic             neg_q, ovf_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q, rdy_q, busy_q;

    logic             start, iter_en, last_iter, mul_exc;
    logic [CW-1:0]    iter_last;
    logic [WIDTH:0]   mul_hi;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign iter_en   = (state_q == MULT) || (state_q == DIV);
    assign iter_last = (op_q == OP_MULT) ? MULT_LAST : DIV_LAST;

    iter_counter #(.CW(CW)) u_iter_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (start),
        .en_i    (iter_en),
        .last_i  (iter_last),
        .tc_o    (last_iter)
    );

    // prod_q = {accumulator, multiplier, q[-1]}; the add is done one bit wider so
    // that +/- most-negative multiplicands cannot wrap before the arithmetic shift.
`ifdef MULTDIV_BOOTH4_EN
    logic [WIDTH+1:0] pp_add, pp_sum;
    always_comb begin
        pp_add = '0;
        case (prod_q[2:0])
            3'b001, 3'b010: pp_add = {{2{mcand_q[WIDTH-1]}}, mcand_q};
            3'b011:         pp_add = {mcand_q[WIDTH-1], mcand_q, 1'b0};
            3'b100:         pp_add = ~{mcand_q[WIDTH-1], mcand_q, 1'b0} + 1'b1;
            3'b101, 3'b110: pp_add = ~{{2{mcand_q[WIDTH-1]}}, mcand_q} + 1'b1;
            default:        pp_add = '0;
        endcase
        pp_sum = {{2{prod_q[2*WIDTH]}}, prod_q[2*WIDTH:WIDTH+1]} + pp_add;
        prod_d = {pp_sum, prod_q[WIDTH:2]};
    end
`else
    logic [WIDTH:0] pp_add, pp_sum;
    always_comb begin
        pp_add = '0;
        case (prod_q[1:0])
            2'b01:   pp_add = {mcand_q[WIDTH-1], mcand_q};
            2'b10:   pp_add = ~{mcand_q[WIDTH-1], mcand_q} + 1'b1;
            default: pp_add = '0;
        endcase
        pp_sum = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]} + pp_add;
        prod_d = {pp_sum, prod_q[WIDTH:1]};
    end
`endif

    assign mul_hi  = prod_d[2*WIDTH:WIDTH];
    assign mul_exc = ~((&mul_hi) | ~(|mul_hi));

    // Non-restoring step: the quotient bits come out final, only the remainder needs fixing.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_d     = rem_q[WIDTH] ? (rem_shift + {1'b0, dvsr_q}) : (rem_shift - {1'b0, dvsr_q});
        quo_d     = {quo_q[WIDTH-2:0], ~rem_d[WIDTH]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            prod_q   <= '0;
            mcand_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (start) begin
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.ctrl_MULT) begin
                state_q <= MULT;
                op_q    <= OP_MULT;
                mcand_q <= bus.data_operandA;
                prod_q  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            end else begin
                op_q   <= OP_DIV;
                rem_q  <= '0;
                quo_q  <= magnitude(bus.data_operandA);
                dvsr_q <= magnitude(bus.data_operandB);
                neg_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                ovf_q  <= (bus.data_operandA == MOST_NEG) && (&bus.data_operandB);
                if (bus.data_operandB == '0) begin
                    state_q  <= DONE;
                    result_q <= '0;
                    exc_q    <= 1'b1;
                    rdy_q    <= 1'b1;
                    busy_q   <= 1'b0;
                end else begin
                    state_q <= DIV;
                end
            end
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                MULT: begin
                    prod_q <= prod_d;
                    if (last_iter) begin
                        state_q  <= DONE;
                        result_q <= prod_d[WIDTH:1];
                        exc_q    <= mul_exc;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (last_iter) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (rem_q[WIDTH]) begin
                        rem_q <= rem_q + {1'b0, dvsr_q};
                    end
                    result_q <= neg_q ? (~quo_q + 1'b1) : quo_q;
                    exc_q    <= ovf_q;
                    state_q  <= DONE;
                    rdy_q    <= 1'b1;
                    busy_q   <= 1'b0;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.data_busy      = busy_q;
endmodule
